spi_arbiter: RTL and testbench
==============================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL provide parameter: TIMEOUT_CYCLES, default 4096, BOARD_CLOCK cycles allowed per transaction before abort (16-bit counter).
REQ-002 SHALL have port: BOARD_CLOCK  in  1  single clock; all logic rising-edge.
REQ-003 SHALL have port: RST  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: REQ_I  in  3  per-requester request level (bit0 = PCI host, bit1 = poller, bit2 = config loader).
REQ-005 SHALL have port: CMD_I  in  96  per-requester 32-bit SPI word, requester n at bits [32n+31:32n].
REQ-006 SHALL have port: SEL_I  in  6  per-requester 2-bit chip select index, requester n at [2n+1:2n].
REQ-007 SHALL have port: ACK_O  in/out: out  3  one-cycle completion pulse to granted requester.
REQ-008 SHALL have port: ERR_O  out  1  asserted with ACK_O when transaction timed out.
REQ-009 SHALL have port: RDATA_O  out  32  SPI read word of last completed transaction.
REQ-010 SHALL have port: BUSY_O  out  1  high in any state other than IDLE.
REQ-011 SHALL have ports to SPI master: SPI_I_O out 32 command word; SPI_SEL_O out 2 chip select; SPI_STAR_O out 1 start level; SPI_DONE_I in 1 done level; SPI_O_I in 32 read word.

Function
REQ-012 SHALL implement states IDLE, START, RELEASE, ACK.
REQ-013 IDLE: when any REQ_I bit high AND SPI_DONE_I==0, SHALL select winner by round-robin, register winner's CMD/SEL into SPI_I_O/SPI_SEL_O, enter START next cycle.
REQ-014 IDLE with SPI_DONE_I==1 SHALL issue nothing (stale done after master reset/abort).
REQ-015 Round-robin: search starts at (last_grant+1) mod 3; wraps 2->0; last_grant updates only on grant.
REQ-016 START: SPI_STAR_O=1; on SPI_DONE_I==1 SHALL capture SPI_O_I into RDATA_O, drop SPI_STAR_O, enter RELEASE.
REQ-017 RELEASE: SPI_STAR_O=0; on SPI_DONE_I==0 SHALL enter ACK.
REQ-018 ACK: SHALL pulse ACK_O[winner] for exactly one cycle, ERR_O=0, return to IDLE.
REQ-019 SPI_I_O/SPI_SEL_O SHALL stay stable from START entry until IDLE re-entry.
REQ-020 Requester SHALL hold REQ_I/CMD_I/SEL_I stable until its ACK; REQ_I still high in cycle after ACK is a new request.
REQ-021 Minimum latency REQ_I to ACK_O: 4 cycles with immediate done edges; no grant in same cycle as ACK.
REQ-022 Requests changing while BUSY_O high SHALL not affect current transaction.
REQ-023 RDATA_O SHALL hold its value between captures; write-only transactions still capture SPI_O_I.

Reset
REQ-024 RST SHALL force: state IDLE, SPI_STAR_O=0, ACK_O=0, ERR_O=0, BUSY_O=0, RDATA_O=0, SPI_I_O=0, SPI_SEL_O=0, last_grant=2 (requester 0 highest priority), timeout counter 0.
REQ-025 RST mid-transaction SHALL abort without ACK_O pulse.

Configuration
REQ-026 Macro SPI_ARB_TIMEOUT_EN defined: counter clears on START entry, increments each START/RELEASE cycle; reaching TIMEOUT_CYCLES SHALL drop SPI_STAR_O, pulse ACK_O[winner] and ERR_O together one cycle, RDATA_O unchanged, go IDLE.
REQ-027 Macro undefined: no counter, ERR_O tied 0, START/RELEASE wait indefinitely.

Verification
REQ-028 REQ_I=001, CMD0=0x0000_00AE, SEL0=2, model done after 10 cycles, SPI_O_I=0x1234_5678 -> SPI_SEL_O=2, SPI_I_O=0x0000_00AE, ACK_O=001 once, RDATA_O=0x1234_5678.
REQ-029 REQ_I=111 held continuously after reset -> grant order 0,1,2,0,1,2.
REQ-030 Last grant 1, then REQ_I=101 -> requester 2 granted before 0.
REQ-031 SPI_DONE_I held 1 after reset, REQ_I=010 -> no SPI_STAR_O until done falls, then normal ACK_O=010.
REQ-032 SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, done never rises -> SPI_STAR_O falls and ACK_O=001 with ERR_O=1 at cycle 16 after START.
REQ-033 RST pulsed in RELEASE -> all outputs at reset values next cycle, no ACK_O.

Source files
------------

// File: rtl/spi_arbiter.sv
// Three-requester round-robin arbiter in front of a single SPI master.
// Optional transaction timeout/abort is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        BOARD_CLOCK,
  input  logic        RST,
  input  logic [2:0]  REQ_I,
  input  logic [95:0] CMD_I,
  input  logic [5:0]  SEL_I,
  output logic [2:0]  ACK_O,
  output logic        ERR_O,
  output logic [31:0] RDATA_O,
  output logic        BUSY_O,
  output logic [31:0] SPI_I_O,
  output logic [1:0]  SPI_SEL_O,
  output logic        SPI_STAR_O,
  input  logic        SPI_DONE_I,
  input  logic [31:0] SPI_O_I
);

  typedef enum logic [1:0] {IDLE, START, RELEASE, ACK} state_t;

  state_t      r_state;
  logic [1:0]  r_last;
  logic [1:0]  r_win;
  logic [2:0]  r_ack;
  logic [31:0] r_rdata;
  logic [31:0] r_cmd;
  logic [1:0]  r_sel;
  logic        r_star;

  logic [1:0]  w_c0, w_c1, w_c2, w_win;
  logic [31:0] w_cmd;
  logic [1:0]  w_sel;
  logic        w_any;

  function automatic logic [1:0] rr_next(input logic [1:0] g);
    return (g >= 2'd2) ? 2'd0 : g + 2'd1;
  endfunction

  // Search order starts just after the previous winner and wraps 2 -> 0.
  always_comb begin
    w_c0  = rr_next(r_last);
    w_c1  = rr_next(w_c0);
    w_c2  = rr_next(w_c1);
    w_any = |REQ_I;
    if (REQ_I[w_c0])      w_win = w_c0;
    else if (REQ_I[w_c1]) w_win = w_c1;
    else                  w_win = w_c2;
  end

  always_comb begin
    case (w_win)
      2'd1:    begin w_cmd = CMD_I[63:32]; w_sel = SEL_I[3:2]; end
      2'd2:    begin w_cmd = CMD_I[95:64]; w_sel = SEL_I[5:4]; end
      default: begin w_cmd = CMD_I[31:0];  w_sel = SEL_I[1:0]; end
    endcase
  end

`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        r_err;
  logic        w_tmo;
  assign w_tmo = (r_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign ERR_O = r_err;
`else
  logic w_unused;
  assign w_unused = ^(16'(TIMEOUT_CYCLES));
  assign ERR_O    = 1'b0;
`endif

  always_ff @(posedge BOARD_CLOCK) begin
    if (RST) begin
      r_state <= IDLE;
      r_star  <= 1'b0;
      r_ack   <= 3'b000;
      r_rdata <= 32'd0;
      r_cmd   <= 32'd0;
      r_sel   <= 2'd0;
      r_last  <= 2'd2;
      r_win   <= 2'd0;
`ifdef SPI_ARB_TIMEOUT_EN
      r_cnt   <= 16'd0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_ack <= 3'b000;
`ifdef SPI_ARB_TIMEOUT_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          // A done level still high here is stale; wait for it to clear.
          if (w_any && !SPI_DONE_I) begin
            r_win   <= w_win;
            r_last  <= w_win;
            r_cmd   <= w_cmd;
            r_sel   <= w_sel;
            r_star  <= 1'b1;
            r_state <= START;
`ifdef SPI_ARB_TIMEOUT_EN
            r_cnt   <= 16'd0;
`endif
          end
        end
        START: begin
`ifdef SPI_ARB_TIMEOUT_EN
          r_cnt <= r_cnt + 16'd1;
          if (w_tmo) begin
            r_star  <= 1'b0;
            r_ack   <= 3'(1) << r_win;
            r_err   <= 1'b1;
            r_state <= ACK;
          end else
`endif
          if (SPI_DONE_I) begin
            r_rdata <= SPI_O_I;
            r_star  <= 1'b0;
            r_state <= RELEASE;
          end
        end
        RELEASE: begin
`ifdef SPI_ARB_TIMEOUT_EN
          r_cnt <= r_cnt + 16'd1;
          if (w_tmo) begin
            r_ack   <= 3'(1) << r_win;
            r_err   <= 1'b1;
            r_state <= ACK;
          end else
`endif
          if (!SPI_DONE_I) begin
            r_ack   <= 3'(1) << r_win;
            r_state <= ACK;
          end
        end
        ACK:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ACK_O      = r_ack;
  assign RDATA_O    = r_rdata;
  assign BUSY_O     = (r_state != IDLE);
  assign SPI_I_O    = r_cmd;
  assign SPI_SEL_O  = r_sel;
  assign SPI_STAR_O = r_star;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a behavioural SPI master and an ACK scoreboard.
module tb_spi_arbiter;
  localparam logic [31:0] XORK = 32'h5A5A_0F0F;

  logic        clk = 1'b0;
  logic        RST;
  logic [2:0]  REQ_I;
  logic [95:0] CMD_I;
  logic [5:0]  SEL_I;
  logic [2:0]  ACK_O;
  logic        ERR_O;
  logic [31:0] RDATA_O;
  logic        BUSY_O;
  logic [31:0] SPI_I_O;
  logic [1:0]  SPI_SEL_O;
  logic        SPI_STAR_O;
  logic        SPI_DONE_I;
  logic [31:0] SPI_O_I;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] cmd;
    logic [1:0]  sel;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          ack_cyc = 0;
  int          st_cyc = 0;
  logic [31:0] cmd_arr [3];
  logic [1:0]  sel_arr [3];
  logic [31:0] last_rd;
  int          m_mode;   // 0 normal, 1 never done, 2 done stuck high, 3 done never falls
  int          m_delay;
  int          m_cnt;
  logic        m_fixed;
  logic [31:0] m_rd;

  spi_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .BOARD_CLOCK(clk), .RST(RST), .REQ_I(REQ_I), .CMD_I(CMD_I), .SEL_I(SEL_I),
    .ACK_O(ACK_O), .ERR_O(ERR_O), .RDATA_O(RDATA_O), .BUSY_O(BUSY_O),
    .SPI_I_O(SPI_I_O), .SPI_SEL_O(SPI_SEL_O), .SPI_STAR_O(SPI_STAR_O),
    .SPI_DONE_I(SPI_DONE_I), .SPI_O_I(SPI_O_I)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural SPI master reacting just after each clock edge.
  always @(posedge clk) begin
    #1;
    case (m_mode)
      1: SPI_DONE_I = 1'b0;
      2: SPI_DONE_I = 1'b1;
      default: begin
        if (SPI_STAR_O && !SPI_DONE_I) begin
          if (m_cnt >= m_delay) begin
            SPI_DONE_I = 1'b1;
            SPI_O_I    = m_fixed ? m_rd : (SPI_I_O ^ XORK);
            m_cnt      = 0;
          end else m_cnt++;
        end else if (!SPI_STAR_O && SPI_DONE_I && m_mode == 0) begin
          SPI_DONE_I = 1'b0;
        end
      end
    endcase
  end

  always @(negedge clk) begin
    exp_t e;
    if (ACK_O !== 3'b000) begin
      ack_cyc = cyc;
      if (sbq.size() == 0) chk("spurious_ack", {29'd0, ACK_O}, 32'd0);
      else begin
        e = sbq.pop_front();
        chk("ack_onehot", {29'd0, ACK_O}, 32'd1 << e.id);
        chk("ack_err", {31'd0, ERR_O}, {31'd0, e.err});
        chk("ack_rdata", RDATA_O, e.rd);
        chk("ack_cmd", SPI_I_O, e.cmd);
        chk("ack_sel", {30'd0, SPI_SEL_O}, {30'd0, e.sel});
        chk("ack_star_low", {31'd0, SPI_STAR_O}, 32'd0);
      end
    end
  end

  task automatic load_cmds();
    CMD_I = {cmd_arr[2], cmd_arr[1], cmd_arr[0]};
    SEL_I = {sel_arr[2], sel_arr[1], sel_arr[0]};
  endtask

  task automatic push_exp(input int id, input logic err);
    exp_t e;
    e.id  = 2'(id);
    e.cmd = cmd_arr[id];
    e.sel = sel_arr[id];
    e.err = err;
    e.rd  = err ? last_rd : (m_fixed ? m_rd : (cmd_arr[id] ^ XORK));
    last_rd = e.rd;
    sbq.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    RST = 1'b1; REQ_I = 3'b000;
    @(negedge clk);
    @(negedge clk);
    RST = 1'b0; last_rd = 32'd0;
  endtask

  task automatic drain(input int lim);
    for (int i = 0; i < lim && sbq.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    chk("drain", sbq.size(), 32'd0);
    REQ_I = 3'b000;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_star"},  {31'd0, SPI_STAR_O}, 32'd0);
    chk({tag, "_ack"},   {29'd0, ACK_O}, 32'd0);
    chk({tag, "_err"},   {31'd0, ERR_O}, 32'd0);
    chk({tag, "_busy"},  {31'd0, BUSY_O}, 32'd0);
    chk({tag, "_rdata"}, RDATA_O, 32'd0);
    chk({tag, "_cmd"},   SPI_I_O, 32'd0);
    chk({tag, "_sel"},   {30'd0, SPI_SEL_O}, 32'd0);
  endtask

  initial begin
    RST = 1'b1; REQ_I = 3'b000; SPI_DONE_I = 1'b0; SPI_O_I = 32'd0;
    m_mode = 0; m_delay = 2; m_cnt = 0; m_fixed = 1'b0; m_rd = 32'd0; last_rd = 32'd0;
    cmd_arr[0] = 32'h0000_00AE; cmd_arr[1] = 32'hC0DE_0011; cmd_arr[2] = 32'hBEEF_0022;
    sel_arr[0] = 2'd2; sel_arr[1] = 2'd1; sel_arr[2] = 2'd3;
    load_cmds();
    do_reset();
    #1;
    chk_reset_vals("reset");

    // Single read on requester 0 with a slow master.
    m_fixed = 1'b1; m_rd = 32'h1234_5678; m_delay = 10;
    push_exp(0, 1'b0);
    REQ_I = 3'b001;
    drain(100);
    @(negedge clk); #1;
    chk("rdata_hold", RDATA_O, 32'h1234_5678);
    chk("idle_after_ack", {31'd0, BUSY_O}, 32'd0);
    m_fixed = 1'b0; m_delay = 2;

    // All three requesting: strict rotation from requester 0.
    do_reset();
    for (int k = 0; k < 6; k++) push_exp(k % 3, 1'b0);
    REQ_I = 3'b111;
    drain(300);

    // Last grant 1, then 0 and 2 compete: 2 goes first.
    do_reset();
    push_exp(1, 1'b0);
    REQ_I = 3'b010;
    drain(60);
    push_exp(2, 1'b0);
    push_exp(0, 1'b0);
    REQ_I = 3'b101;
    drain(120);

`ifdef SPI_ARB_TIMEOUT_EN
    // Master never answers: abort with ERR after 16 cycles, RDATA kept.
    m_mode = 1;
    push_exp(0, 1'b1);
    REQ_I = 3'b001;
    for (int i = 0; i < 20 && !SPI_STAR_O; i++) begin @(negedge clk); #1; end
    chk("tmo_star_rise", {31'd0, SPI_STAR_O}, 32'd1);
    st_cyc = cyc;
    drain(60);
    chk("tmo_cycles", ack_cyc - st_cyc, 32'd16);
    m_mode = 0;
    @(negedge clk);
`endif

    // Stale done after reset blocks the grant until it falls.
    m_mode = 2;
    do_reset();
    REQ_I = 3'b010;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      chk("stale_star", {31'd0, SPI_STAR_O}, 32'd0);
    end
    chk("stale_busy", {31'd0, BUSY_O}, 32'd0);
    push_exp(1, 1'b0);
    m_mode = 0;
    drain(60);

    // Reset while waiting in RELEASE aborts without an ACK.
    do_reset();
    m_mode = 3;
    REQ_I = 3'b001;
    for (int i = 0; i < 40 && !(BUSY_O && !SPI_STAR_O); i++) begin @(negedge clk); #1; end
    chk("in_release", {30'd0, BUSY_O, SPI_STAR_O}, 32'd2);
    chk("release_rdata", RDATA_O, cmd_arr[0] ^ XORK);
    RST = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("midrst");
    RST = 1'b0; REQ_I = 3'b000; m_mode = 0;
    repeat (8) @(negedge clk);
    chk("midrst_busy", {31'd0, BUSY_O}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
